// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction memory that fills itself after reset, then serves 1-cycle fetches and byte-masked writes
module instr_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter logic [DATA_W-1:0] FILL = DATA_W'(32'h0000000F)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic              busy,
    output logic              wr_drop
);
    localparam int NB = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] wr_word;
    logic run, accept, wr_run;

    assign run = state_q == RUN;
    assign busy = !run;
    assign req_ready = run && (!rsp_valid_q || rsp_ready);
    assign accept = req_valid && req_ready;
    assign wr_run = run && wr_en;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data = rsp_data_q;
    assign wr_drop = wr_drop_q;

    // Merged word a write would leave behind; also the write-first bypass for a same-address fetch
    always_comb begin
        wr_word = mem_q[wr_addr];
        for (int k = 0; k < NB; k++)
            if (wr_be[k]) wr_word[8*k +: 8] = wr_data[8*k +: 8];
    end

    // Next state: INIT sweeps the counter once, RUN serves the fetch handshake
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d = rsp_data_q;
        wr_drop_d = !run && wr_en;
        if (!run) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = RUN;
        end
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d = (wr_run && wr_addr == req_addr) ? wr_word : mem_q[req_addr];
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q <= rsp_data_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage: fill word during INIT, byte-merged user write during RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) mem_q[cnt_q] <= FILL;
            else if (wr_en) mem_q[wr_addr] <= wr_word;
        end
    end
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: directed scoreboard bench for instr_mem_ctrl
module tb_instr_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [7:0] req_addr = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0] wr_be = '0;
    logic busy;
    logic wr_drop;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    instr_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .busy(busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] a, input logic [31:0] e);
        req_valid = 1'b1;
        req_addr = a;
        exp_q.push_back(e);
        tick();
        chk("rsp_valid_after_accept", {31'b0, rsp_valid}, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be = be;
        tick();
        chk("wr_drop_run", {31'b0, wr_drop}, 32'd0);
        wr_en = 1'b0;
    endtask

    task automatic wait_init();
        int n = 0;
        while (busy && n < 1000) begin
            n++;
            if (n == 1) begin
                wr_en = 1'b1;
                wr_addr = 8'h40;
                wr_data = 32'h11111111;
                wr_be = 4'hF;
            end else begin
                wr_en = 1'b0;
            end
            if (n == 2) chk("wr_drop_pulse", {31'b0, wr_drop}, 32'd1);
            if (n == 3) chk("wr_drop_clear", {31'b0, wr_drop}, 32'd0);
            chk("req_ready_init", {31'b0, req_ready}, 32'd0);
            tick();
        end
        chk("init_cycles", n, 32'd256);
        chk("busy_run", {31'b0, busy}, 32'd0);
        chk("req_ready_run", {31'b0, req_ready}, 32'd1);
    endtask

    // Monitor: every completed response handshake is checked against the oldest expectation
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got %h expected none", rsp_data);
            end else begin
                chk("rsp_data", rsp_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick();
        tick();
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_wr_drop", {31'b0, wr_drop}, 32'd0);
        rst = 1'b0;
        wait_init();

        fetch(8'h00, 32'h0000000F);
        fetch(8'd127, 32'h0000000F);
        fetch(8'd255, 32'h0000000F);
        fetch(8'h40, 32'h0000000F);
        tick();
        chk("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);

        write(8'h10, 32'hDEADBEEF, 4'hF);
        write(8'h10, 32'h00000055, 4'h1);
        write(8'h10, 32'hFFFFFFFF, 4'h0);
        fetch(8'h10, 32'hDEADBE55);
        tick();
        chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);

        rsp_ready = 1'b0;
        fetch(8'h20, 32'h0000000F);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_data", rsp_data, 32'h0000000F);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            wr_en = (i == 0);
            wr_addr = 8'h20;
            wr_data = 32'h12345678;
            wr_be = 4'hF;
            req_valid = 1'b1;
            req_addr = 8'h21;
            tick();
        end
        wr_en = 1'b0;
        req_valid = 1'b0;
        chk("hold_data_after_write", rsp_data, 32'h0000000F);
        rsp_ready = 1'b1;
        tick();
        chk("rsp_valid_release", {31'b0, rsp_valid}, 32'd0);
        fetch(8'h20, 32'h12345678);

        wr_en = 1'b1;
        wr_addr = 8'h30;
        wr_data = 32'hAABBCCDD;
        wr_be = 4'b1100;
        fetch(8'h30, 32'hAABB000F);
        wr_en = 1'b0;
        fetch(8'h30, 32'hAABB000F);
        wr_en = 1'b1;
        wr_addr = 8'h50;
        wr_data = 32'hCAFEF00D;
        wr_be = 4'hF;
        fetch(8'h40, 32'h0000000F);
        wr_en = 1'b0;
        fetch(8'h50, 32'hCAFEF00D);
        tick();

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 8'h60;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_valid", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd1);
        rsp_ready = 1'b1;
        wait_init();
        fetch(8'h10, 32'h0000000F);
        fetch(8'h20, 32'h0000000F);
        fetch(8'h30, 32'h0000000F);
        fetch(8'h50, 32'h0000000F);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            tick();
        end
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
